// File: rtl/sram_dp_sync_param_if.sv
// Port bundle for sram_dp_sync_param: two independent request/response ports
// plus the clear-busy and cross-port collision status lines.
interface sram_dp_sync_param_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 18
);
  logic              cen_a;
  logic              wen_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] wmsk_a;
  logic [DATA_W-1:0] wdata_a;
  logic [DATA_W-1:0] rdata_a;
  logic              rvalid_a;

  logic              cen_b;
  logic              wen_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] wmsk_b;
  logic [DATA_W-1:0] wdata_b;
  logic [DATA_W-1:0] rdata_b;
  logic              rvalid_b;

  logic              busy;
  logic              collision;

  modport master (
    output cen_a, wen_a, addr_a, wmsk_a, wdata_a,
    output cen_b, wen_b, addr_b, wmsk_b, wdata_b,
    input  rdata_a, rvalid_a, rdata_b, rvalid_b, busy, collision
  );

  modport slave (
    input  cen_a, wen_a, addr_a, wmsk_a, wdata_a,
    input  cen_b, wen_b, addr_b, wmsk_b, wdata_b,
    output rdata_a, rvalid_a, rdata_b, rvalid_b, busy, collision
  );
endinterface

// File: rtl/sram_dp_sync_param.sv
// Single-clock true dual-port SRAM with bit-masked writes, optional output
// register, selectable read-during-write behaviour and a post-reset clear sweep.
module sram_dp_sync_param #(
  parameter int                 ADDR_W         = 10,
  parameter int                 DATA_W         = 18,
  parameter int                 OUT_REG        = 0,
  parameter int                 RDW_MODE       = 0,
  parameter int                 CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0]  INIT_VAL       = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sram_dp_sync_param_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NSTG  = (OUT_REG != 0) ? 2 : 1;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_e;
  localparam state_e RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

  typedef struct packed {
    logic              vld;
    logic [DATA_W-1:0] data;
  } rd_stage_t;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              clr_we;

  logic [DATA_W-1:0] mem_q [DEPTH];

  rd_stage_t         pipe_a_q [NSTG];
  rd_stage_t         pipe_b_q [NSTG];
  rd_stage_t         pipe_a_d, pipe_b_d;
  logic [NSTG-1:0]   col_q;
  logic              col_d;

  logic [DATA_W-1:0] rdata_a_q, rdata_b_q;
  logic              rvalid_a_q, rvalid_b_q, collision_q;

  // ---------------------------------------------------------------- clear FSM
  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    clr_we     = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we     = 1'b1;
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == '1) state_d = ST_IDLE;
      end
      ST_IDLE:  state_d = ST_IDLE;
      default:  state_d = RST_STATE;
    endcase
  end

  // ------------------------------------------------------------ access decode
  logic              idle_en, same_addr;
  logic              wr_a, rd_a, wr_b, rd_b, wr_b_eff, ww_col;
  logic [DATA_W-1:0] old_a, old_b, upd_a, upd_b, wr_word_a;
  logic [DATA_W-1:0] rd_word_a, rd_word_b;

  assign idle_en   = (state_q == ST_IDLE);
  assign same_addr = (bus.addr_a == bus.addr_b);
  assign wr_a      = idle_en & ~bus.cen_a & ~bus.wen_a;
  assign rd_a      = idle_en & ~bus.cen_a &  bus.wen_a;
  assign wr_b      = idle_en & ~bus.cen_b & ~bus.wen_b;
  assign rd_b      = idle_en & ~bus.cen_b &  bus.wen_b;
  assign ww_col    = wr_a & wr_b & same_addr;
  assign wr_b_eff  = wr_b & ~ww_col;

  assign old_a = mem_q[bus.addr_a];
  assign old_b = mem_q[bus.addr_b];
  assign upd_a = (old_a & bus.wmsk_a) | (bus.wdata_a & ~bus.wmsk_a);
  assign upd_b = (old_b & bus.wmsk_b) | (bus.wdata_b & ~bus.wmsk_b);

  // Same-word double write: A's unmasked bits win, B fills bits only it writes.
  assign wr_word_a = ww_col
    ? ((old_a & bus.wmsk_a & bus.wmsk_b) | (bus.wdata_a & ~bus.wmsk_a) |
       (bus.wdata_b & ~bus.wmsk_b & bus.wmsk_a))
    : upd_a;

  assign rd_word_a = ((RDW_MODE != 0) && wr_b && same_addr) ? upd_b : old_a;
  assign rd_word_b = ((RDW_MODE != 0) && wr_a && same_addr) ? upd_a : old_b;

  assign col_d    = idle_en & ~bus.cen_a & ~bus.cen_b & same_addr & (~bus.wen_a | ~bus.wen_b);
  assign pipe_a_d = '{vld: rd_a, data: rd_word_a};
  assign pipe_b_d = '{vld: rd_b, data: rd_word_b};

  // -------------------------------------------------------------------- array
  // NOTE: the storage array deliberately has no reset so it maps onto block
  // RAM; initial contents come from the clear sweep instead.
  always_ff @(posedge clk) begin
    if (clr_we)   mem_q[clr_addr_q] <= INIT_VAL;
    if (wr_a)     mem_q[bus.addr_a] <= wr_word_a;
    if (wr_b_eff) mem_q[bus.addr_b] <= upd_b;
  end

  // ------------------------------------------------ state and read pipeline
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RST_STATE;
      clr_addr_q <= '0;
      for (int i = 0; i < NSTG; i++) begin
        pipe_a_q[i] <= '0;
        pipe_b_q[i] <= '0;
      end
      col_q       <= '0;
      rdata_a_q   <= '0;
      rdata_b_q   <= '0;
      rvalid_a_q  <= 1'b0;
      rvalid_b_q  <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      pipe_a_q[0] <= pipe_a_d;
      pipe_b_q[0] <= pipe_b_d;
      col_q[0]    <= col_d;
      for (int i = 1; i < NSTG; i++) begin
        pipe_a_q[i] <= pipe_a_q[i-1];
        pipe_b_q[i] <= pipe_b_q[i-1];
        col_q[i]    <= col_q[i-1];
      end
      // Read data holds its last value between reads.
      rvalid_a_q  <= pipe_a_q[NSTG-1].vld;
      rvalid_b_q  <= pipe_b_q[NSTG-1].vld;
      collision_q <= col_q[NSTG-1];
      if (pipe_a_q[NSTG-1].vld) rdata_a_q <= pipe_a_q[NSTG-1].data;
      if (pipe_b_q[NSTG-1].vld) rdata_b_q <= pipe_b_q[NSTG-1].data;
    end
  end

  assign bus.rdata_a   = rdata_a_q;
  assign bus.rvalid_a  = rvalid_a_q;
  assign bus.rdata_b   = rdata_b_q;
  assign bus.rvalid_b  = rvalid_b_q;
  assign bus.busy      = (state_q == ST_CLEAR);
  assign bus.collision = collision_q;

endmodule

// File: tb/tb_sram_dp_sync_param.sv
// Directed bench: two instances share stimulus, dut0 (OUT_REG=0, RDW_MODE=0)
// and dut1 (OUT_REG=1, RDW_MODE=1), each checked at its own read latency.
module tb_sram_dp_sync_param;
  localparam int AW = 10;
  localparam int DW = 18;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sram_dp_sync_param_if #(.ADDR_W(AW), .DATA_W(DW)) if0 ();
  sram_dp_sync_param_if #(.ADDR_W(AW), .DATA_W(DW)) if1 ();

  sram_dp_sync_param #(.ADDR_W(AW), .DATA_W(DW), .OUT_REG(0), .RDW_MODE(0),
                       .CLEAR_ON_RESET(1), .INIT_VAL('0))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));

  sram_dp_sync_param #(.ADDR_W(AW), .DATA_W(DW), .OUT_REG(1), .RDW_MODE(1),
                       .CLEAR_ON_RESET(1), .INIT_VAL('0))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit pb, input logic cen, input logic wen, input logic [AW-1:0] addr,
                       input logic [DW-1:0] msk, input logic [DW-1:0] data);
    if (!pb) begin
      if0.cen_a = cen; if0.wen_a = wen; if0.addr_a = addr; if0.wmsk_a = msk; if0.wdata_a = data;
      if1.cen_a = cen; if1.wen_a = wen; if1.addr_a = addr; if1.wmsk_a = msk; if1.wdata_a = data;
    end else begin
      if0.cen_b = cen; if0.wen_b = wen; if0.addr_b = addr; if0.wmsk_b = msk; if0.wdata_b = data;
      if1.cen_b = cen; if1.wen_b = wen; if1.addr_b = addr; if1.wmsk_b = msk; if1.wdata_b = data;
    end
  endtask

  task automatic rd(input bit pb, input logic [AW-1:0] addr);
    drive(pb, 1'b0, 1'b1, addr, '1, '0);
  endtask

  task automatic wr(input bit pb, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                    input logic [DW-1:0] msk);
    drive(pb, 1'b0, 1'b0, addr, msk, data);
  endtask

  task automatic idle();
    drive(1'b0, 1'b1, 1'b1, '0, '1, '0);
    drive(1'b1, 1'b1, 1'b1, '0, '1, '0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic outs(input int d, input string tag, input bit va, input logic [DW-1:0] da,
                      input bit vb, input logic [DW-1:0] db, input bit col);
    logic rva, rvb, cl;
    logic [DW-1:0] ra, rb;
    if (d == 0) begin
      rva = if0.rvalid_a; ra = if0.rdata_a; rvb = if0.rvalid_b; rb = if0.rdata_b; cl = if0.collision;
    end else begin
      rva = if1.rvalid_a; ra = if1.rdata_a; rvb = if1.rvalid_b; rb = if1.rdata_b; cl = if1.collision;
    end
    check($sformatf("%s.d%0d.rvalid_a", tag, d), 32'(rva), 32'(va));
    if (va) check($sformatf("%s.d%0d.rdata_a", tag, d), 32'(ra), 32'(da));
    check($sformatf("%s.d%0d.rvalid_b", tag, d), 32'(rvb), 32'(vb));
    if (vb) check($sformatf("%s.d%0d.rdata_b", tag, d), 32'(rb), 32'(db));
    check($sformatf("%s.d%0d.collision", tag, d), 32'(cl), 32'(col));
  endtask

  // Inputs for edge T are already driven; dut0 answers after T+1, dut1 after T+2.
  task automatic txn(input string tag, input bit va, input logic [DW-1:0] da0, input logic [DW-1:0] da1,
                     input bit vb, input logic [DW-1:0] db0, input logic [DW-1:0] db1, input bit col);
    step();
    idle();
    outs(0, {tag, "@T"}, 1'b0, '0, 1'b0, '0, 1'b0);
    outs(1, {tag, "@T"}, 1'b0, '0, 1'b0, '0, 1'b0);
    step();
    outs(0, {tag, "@T+1"}, va, da0, vb, db0, col);
    outs(1, {tag, "@T+1"}, 1'b0, '0, 1'b0, '0, 1'b0);
    step();
    outs(0, {tag, "@T+2"}, 1'b0, '0, 1'b0, '0, 1'b0);
    outs(1, {tag, "@T+2"}, va, da1, vb, db1, col);
  endtask

  // Counts busy cycles from reset release; optionally hammers both ports meanwhile.
  task automatic clear_watch(input string tag, input bit poke);
    int n0 = 0;
    int n1 = 0;
    int ghost = 0;
    if (poke) begin
      wr(1'b0, 10'd7, 18'h3FFFF, '0);
      rd(1'b1, 10'd7);
    end
    for (int k = 0; k < 1100; k++) begin
      if (if0.busy) n0++;
      if (if1.busy) n1++;
      if (!if0.busy && !if1.busy) idle();
      if (if0.rvalid_a || if0.rvalid_b || if0.collision ||
          if1.rvalid_a || if1.rvalid_b || if1.collision) ghost++;
      step();
    end
    check({tag, ".busy_cycles_d0"}, n0, 1024);
    check({tag, ".busy_cycles_d1"}, n1, 1024);
    check({tag, ".spurious_outputs"}, ghost, 0);
  endtask

  task automatic reset_outs(input string tag);
    check({tag, ".busy_d0"}, 32'(if0.busy), 1);
    check({tag, ".busy_d1"}, 32'(if1.busy), 1);
    check({tag, ".rdata_a_d0"}, 32'(if0.rdata_a), 0);
    check({tag, ".rdata_a_d1"}, 32'(if1.rdata_a), 0);
    check({tag, ".rdata_b_d0"}, 32'(if0.rdata_b), 0);
    outs(0, tag, 1'b0, '0, 1'b0, '0, 1'b0);
    outs(1, tag, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    idle();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    reset_outs("reset");
    #19 rst_n = 1'b1;

    // Clear sweep; writes/reads issued during it must be ignored.
    clear_watch("clear1", 1'b1);

    rd(1'b1, 10'd1023);
    txn("rd1023", 1'b0, '0, '0, 1'b1, 18'h0, 18'h0, 1'b0);
    rd(1'b1, 10'd7);
    txn("rd7_after_clear", 1'b0, '0, '0, 1'b1, 18'h0, 18'h0, 1'b0);

    wr(1'b0, 10'd5, 18'h3FFFF, 18'h000FF);
    txn("wr5", 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    rd(1'b1, 10'd5);
    txn("rd5_masked", 1'b0, '0, '0, 1'b1, 18'h3FF00, 18'h3FF00, 1'b0);

    rd(1'b0, 10'd5);
    rd(1'b1, 10'd5);
    txn("rr5_no_col", 1'b1, 18'h3FF00, 18'h3FF00, 1'b1, 18'h3FF00, 18'h3FF00, 1'b0);

    wr(1'b0, 10'd10, 18'h11111, '0);
    wr(1'b1, 10'd10, 18'h22222, '0);
    txn("ww10", 1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    rd(1'b0, 10'd10);
    txn("rd10_a_wins", 1'b1, 18'h11111, 18'h11111, 1'b0, '0, '0, 1'b0);

    // Partial masks: A writes bits 7:0, B writes bits 17:8 and 3:0.
    wr(1'b0, 10'd11, 18'h000AA, 18'h3FF00);
    wr(1'b1, 10'd11, 18'h3FF55, 18'h000F0);
    txn("ww11_merge", 1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    rd(1'b1, 10'd11);
    txn("rd11_merge", 1'b0, '0, '0, 1'b1, 18'h3FFAA, 18'h3FFAA, 1'b0);

    wr(1'b0, 10'd20, 18'h00AAA, '0);
    txn("wr20", 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    wr(1'b0, 10'd20, 18'h00555, '0);
    rd(1'b1, 10'd20);
    txn("rdw20", 1'b0, '0, '0, 1'b1, 18'h00AAA, 18'h00555, 1'b1);
    rd(1'b0, 10'd20);
    txn("rd20_after", 1'b1, 18'h00555, 18'h00555, 1'b0, '0, '0, 1'b0);

    wr(1'b1, 10'd1000, 18'h12345, '0);
    txn("wr1000", 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    rd(1'b0, 10'd1000);
    txn("rd1000", 1'b1, 18'h12345, 18'h12345, 1'b0, '0, '0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      wr(1'b0, AW'(i), DW'(32'h100 + i), '0);
      step();
    end
    idle();
    step();

    // Back-to-back reads @0..3: full throughput, in address order.
    for (int c = 0; c < 7; c++) begin
      logic [DW-1:0] e0, e1;
      if (c < 4) rd(1'b0, AW'(c)); else idle();
      step();
      e0 = DW'(32'h100 + c - 1);
      e1 = DW'(32'h100 + c - 2);
      outs(0, $sformatf("b2b.c%0d", c), (c >= 1 && c <= 4), e0, 1'b0, '0, 1'b0);
      outs(1, $sformatf("b2b.c%0d", c), (c >= 2 && c <= 5), e1, 1'b0, '0, 1'b0);
      if (c == 6) begin
        check("hold.rdata_a_d0", 32'(if0.rdata_a), 32'h103);
        check("hold.rdata_a_d1", 32'(if1.rdata_a), 32'h103);
      end
    end

    // Asynchronous reset clears held read data immediately.
    rst_n = 1'b0;
    #1;
    reset_outs("reset2");
    #4 rst_n = 1'b1;
    repeat (500) step();
    check("mid_clear.busy_d0", 32'(if0.busy), 1);
    check("mid_clear.busy_d1", 32'(if1.busy), 1);
    rst_n = 1'b0;
    #1;
    reset_outs("reset3");
    #4 rst_n = 1'b1;
    clear_watch("clear3", 1'b0);

    rd(1'b0, 10'd1000);
    txn("rd1000_cleared", 1'b1, 18'h0, 18'h0, 1'b0, '0, '0, 1'b0);
    rd(1'b1, 10'd3);
    txn("rd3_cleared", 1'b0, '0, '0, 1'b1, 18'h0, 18'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
